// File: rtl/trigger_sched_pkg.sv
// Shared types and constants for the trigger scheduler.
// State encoding plus a source-index width helper.
package trigger_sched_pkg;

    localparam int NUM_SRC_MAX = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        PULSE   = 2'd2,
        HOLDOFF = 2'd3
    } state_e;

    // Index width for n sources; never narrower than one bit.
    function automatic int src_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/trigger_scheduler_if.sv
// Config, request and status bundle of the trigger scheduler.
// master drives config/requests, slave is the scheduler.
interface trigger_scheduler_if
    import trigger_sched_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 32,
    parameter int DROP_W  = 16
);
    localparam int SRC_W = src_w(NUM_SRC);

    logic [NUM_SRC-1:0] reg_src_enable;
    logic               reg_rr_mode;
    logic [CNT_W-1:0]   reg_delay_cycles;
    logic [CNT_W-1:0]   reg_pulse_cycles;
    logic [CNT_W-1:0]   reg_holdoff_cycles;
    logic               reg_drop_clr;
    logic [NUM_SRC-1:0] trig_req;
    logic               trig_out;
    logic [SRC_W-1:0]   trig_src;
    logic               busy;
    logic [DROP_W-1:0]  drop_cnt;

    modport master (
        output reg_src_enable, reg_rr_mode, reg_delay_cycles,
        output reg_pulse_cycles, reg_holdoff_cycles, reg_drop_clr,
        output trig_req,
        input  trig_out, trig_src, busy, drop_cnt
    );

    modport slave (
        input  reg_src_enable, reg_rr_mode, reg_delay_cycles,
        input  reg_pulse_cycles, reg_holdoff_cycles, reg_drop_clr,
        input  trig_req,
        output trig_out, trig_src, busy, drop_cnt
    );

endinterface

// File: rtl/trig_rr_arbiter.sv
// Combinational picker over the pending bits.
// Fixed mode scans from 0, round-robin scans from ptr with wrap.
module trig_rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) (
    input  logic [NUM_SRC-1:0] pending,
    input  logic [SRC_W-1:0]   ptr,
    input  logic               rr_mode,
    output logic [SRC_W-1:0]   winner,
    output logic               valid
);

    // First pending index at or after the scan start.
    always_comb begin
        int start;
        int idx;
        winner = '0;
        valid  = 1'b0;
        start  = rr_mode ? int'(ptr) : 0;
        idx    = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = start + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!valid && pending[idx]) begin
                valid  = 1'b1;
                winner = SRC_W'(idx);
            end
        end
    end

endmodule

// File: rtl/trigger_scheduler.sv
// Shares one trigger output among several requesters.
// Edge-captured requests are arbitrated, then delayed, pulsed and held off.
module trigger_scheduler
    import trigger_sched_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 32,
    parameter int DROP_W  = 16
) (
    input logic                clk,
    input logic                rst,
    trigger_scheduler_if.slave bus
);

    localparam int SRC_W = src_w(NUM_SRC);

    logic [NUM_SRC-1:0] req_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] req_edge;
    logic [NUM_SRC-1:0] grant_v;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   pulse_q, pulse_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [SRC_W-1:0]   win;
    logic               win_vld;
    logic               grant;
    logic               trig_q, trig_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic [3:0]         ndrop;
    logic [DROP_W+3:0]  drop_sum;

    // Last pulse-phase count; a zero width still gives one cycle.
    function automatic logic [CNT_W-1:0] pulse_last(
        input logic [CNT_W-1:0] p
    );
        return (p == '0) ? '0 : p - CNT_W'(1);
    endfunction

    trig_rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_arb (
        .pending (pend_q),
        .ptr     (ptr_q),
        .rr_mode (bus.reg_rr_mode),
        .winner  (win),
        .valid   (win_vld)
    );

    assign req_edge = bus.trig_req & ~req_q & bus.reg_src_enable;
    assign grant    = (state_q == IDLE) && win_vld;
    assign grant_v  = grant ? (NUM_SRC'(1) << win) : '0;

    // One-deep pending slots and the saturating drop counter.
    always_comb begin
        pend_d = pend_q;
        ndrop  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!bus.reg_src_enable[i]) begin
                pend_d[i] = 1'b0;
            end else if (req_edge[i]) begin
                if (pend_q[i] && !grant_v[i]) ndrop = ndrop + 4'd1;
                pend_d[i] = 1'b1;
            end else if (grant_v[i]) begin
                pend_d[i] = 1'b0;
            end
        end
        drop_sum = (DROP_W+4)'(drop_q) + (DROP_W+4)'(ndrop);
        if (bus.reg_drop_clr) begin
            drop_d = '0;
        end else if (drop_sum[DROP_W+3:DROP_W] != '0) begin
            drop_d = '1;
        end else begin
            drop_d = drop_sum[DROP_W-1:0];
        end
    end

    // Grant, then walk delay -> pulse -> holdoff on one down-counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        hold_d  = hold_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    pulse_d = bus.reg_pulse_cycles;
                    hold_d  = bus.reg_holdoff_cycles;
                    src_d   = win;
                    if (bus.reg_rr_mode) begin
                        ptr_d = (win == SRC_W'(NUM_SRC - 1)) ?
                                '0 : win + SRC_W'(1);
                    end
                    if (bus.reg_delay_cycles != '0) begin
                        state_d = DELAY;
                        cnt_d   = bus.reg_delay_cycles - CNT_W'(1);
                    end else begin
                        state_d = PULSE;
                        cnt_d   = pulse_last(bus.reg_pulse_cycles);
                    end
                end
            end
            DELAY: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = pulse_last(pulse_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    if (hold_q != '0) begin
                        state_d = HOLDOFF;
                        cnt_d   = hold_q - CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        trig_d = (state_d == PULSE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= '0;
            pend_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= '0;
            hold_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
            trig_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            req_q   <= bus.trig_req;
            pend_q  <= pend_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            hold_q  <= hold_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            trig_q  <= trig_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.trig_out = trig_q;
    assign bus.trig_src = src_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_trigger_scheduler.sv
// Directed bench for trigger_scheduler.
// Each task drives one scenario and checks against hand-derived values.
module tb_trigger_scheduler;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [63:0] to_v;
    logic [63:0] bz_v;
    logic [1:0]  src_a [64];

    trigger_scheduler_if bus ();

    trigger_scheduler u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_rec(input int i);
        @(posedge clk);
        #1;
        to_v[i]  = bus.trig_out;
        bz_v[i]  = bus.busy;
        src_a[i] = bus.trig_src;
    endtask

    task automatic set_cfg(input int d, input int p, input int h,
                           input logic rr);
        bus.reg_delay_cycles   = d;
        bus.reg_pulse_cycles   = p;
        bus.reg_holdoff_cycles = h;
        bus.reg_rr_mode        = rr;
    endtask

    task automatic quiet(input int n);
        bus.trig_req = '0;
        to_v = '0;
        bz_v = '0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.reg_src_enable = 4'hF;
        bus.reg_drop_clr   = 1'b0;
        bus.trig_req       = '0;
        set_cfg(0, 1, 0, 1'b0);
        repeat (3) tick();
        n_cmp++;
        if (bus.trig_out !== 1'b0 || bus.busy !== 1'b0 ||
            bus.trig_src !== 2'd0 || bus.drop_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_state got out=%b busy=%b src=%0d drop=%0d want 0/0/0/0",
                     bus.trig_out, bus.busy, bus.trig_src, bus.drop_cnt);
        end
        rst = 1'b0;
        quiet(3);
    endtask

    task automatic test_single();
        set_cfg(0, 4, 0, 1'b0);
        bus.trig_req = 4'b0001;
        for (int i = 0; i < 12; i++) tick_rec(i);
        n_cmp++;
        if (to_v[11:0] !== 12'h01E) begin
            n_bad++;
            $display("FAIL single_trig_out got %h want %h", to_v[11:0], 12'h01E);
        end
        n_cmp++;
        if (bz_v[11:0] !== 12'h01E) begin
            n_bad++;
            $display("FAIL single_busy got %h want %h", bz_v[11:0], 12'h01E);
        end
        n_cmp++;
        if (src_a[2] !== 2'd0) begin
            n_bad++;
            $display("FAIL single_src got %0d want 0", src_a[2]);
        end
        quiet(3);
    endtask

    task automatic test_fixed_prio();
        logic [63:0] exp_v;
        exp_v = (64'h7 << 3) | (64'h7 << 14);
        set_cfg(2, 3, 5, 1'b0);
        bus.trig_req = 4'b1010;
        for (int i = 0; i < 24; i++) tick_rec(i);
        n_cmp++;
        if (to_v[23:0] !== exp_v[23:0]) begin
            n_bad++;
            $display("FAIL fixed_trig_out got %h want %h", to_v[23:0], exp_v[23:0]);
        end
        n_cmp++;
        if (src_a[3] !== 2'd1) begin
            n_bad++;
            $display("FAIL fixed_first_src got %0d want 1", src_a[3]);
        end
        n_cmp++;
        if (src_a[14] !== 2'd3) begin
            n_bad++;
            $display("FAIL fixed_second_src got %0d want 3", src_a[14]);
        end
        quiet(3);
    endtask

    task automatic test_round_robin();
        int exp_src [5] = '{0, 1, 2, 3, 0};
        set_cfg(0, 1, 0, 1'b1);
        bus.trig_req = 4'hF;
        for (int i = 0; i < 12; i++) begin
            tick_rec(i);
            if (i == 0) bus.trig_req = 4'hE;
            if (i == 1) bus.trig_req = 4'hF;
            if (i == 2) bus.trig_req = 4'h0;
        end
        n_cmp++;
        if (to_v[11:0] !== 12'h2AA) begin
            n_bad++;
            $display("FAIL rr_trig_out got %h want %h", to_v[11:0], 12'h2AA);
        end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (src_a[1+2*k] !== 2'(exp_src[k])) begin
                n_bad++;
                $display("FAIL rr_src_%0d got %0d want %0d",
                         k, src_a[1+2*k], exp_src[k]);
            end
        end
        bus.reg_rr_mode = 1'b0;
        quiet(3);
    endtask

    task automatic test_overflow();
        logic [63:0] exp_v;
        exp_v = '0;
        for (int i = 1; i <= 20; i++) exp_v[i] = 1'b1;
        for (int i = 24; i <= 43; i++) exp_v[i] = 1'b1;
        bus.reg_drop_clr = 1'b1;
        tick();
        bus.reg_drop_clr = 1'b0;
        set_cfg(0, 20, 2, 1'b0);
        bus.trig_req = 4'b0100;
        for (int i = 0; i < 50; i++) begin
            tick_rec(i);
            if (i == 0) bus.trig_req = 4'b0000;
            if (i >= 2 && i <= 7) bus.trig_req = (i % 2 == 0) ? 4'b0100 : 4'b0000;
        end
        n_cmp++;
        if (to_v[49:0] !== exp_v[49:0]) begin
            n_bad++;
            $display("FAIL overflow_trig_out got %h want %h", to_v[49:0], exp_v[49:0]);
        end
        n_cmp++;
        if (bus.drop_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL overflow_drop got %0d want 2", bus.drop_cnt);
        end
        quiet(3);
    endtask

    task automatic test_drop_saturate();
        bus.reg_drop_clr = 1'b1;
        tick();
        bus.reg_drop_clr = 1'b0;
        set_cfg(0, 40000, 0, 1'b0);
        bus.trig_req = 4'b0001;
        tick();
        tick();
        for (int c = 0; c < 34000; c++) begin
            bus.trig_req = (c % 2 == 0) ? 4'hF : 4'h0;
            tick();
        end
        n_cmp++;
        if (bus.drop_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL drop_saturate got %h want FFFF", bus.drop_cnt);
        end
        bus.trig_req = 4'h0;
        tick();
        bus.trig_req = 4'hF;
        bus.reg_drop_clr = 1'b1;
        tick();
        bus.reg_drop_clr = 1'b0;
        n_cmp++;
        if (bus.drop_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL drop_clr_priority got %h want 0", bus.drop_cnt);
        end
        bus.trig_req = 4'h0;
        tick();
        bus.trig_req = 4'hF;
        tick();
        n_cmp++;
        if (bus.drop_cnt !== 16'd4) begin
            n_bad++;
            $display("FAIL drop_after_clr got %0d want 4", bus.drop_cnt);
        end
        n_cmp++;
        if (bus.trig_out !== 1'b1) begin
            n_bad++;
            $display("FAIL long_pulse_active got %b want 1", bus.trig_out);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.trig_out !== 1'b0 || bus.busy !== 1'b0 || bus.drop_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_mid_pulse got out=%b busy=%b drop=%0d want 0/0/0",
                     bus.trig_out, bus.busy, bus.drop_cnt);
        end
        bus.trig_req = 4'h0;
        tick();
        rst = 1'b0;
        quiet(3);
    endtask

    task automatic test_config();
        set_cfg(0, 0, 0, 1'b0);
        bus.trig_req = 4'b0010;
        for (int i = 0; i < 6; i++) tick_rec(i);
        n_cmp++;
        if (to_v[5:0] !== 6'h02) begin
            n_bad++;
            $display("FAIL pulse_zero got %h want %h", to_v[5:0], 6'h02);
        end
        quiet(3);
        set_cfg(0, 10, 0, 1'b0);
        bus.trig_req = 4'b0010;
        for (int i = 0; i < 14; i++) begin
            tick_rec(i);
            if (i == 2) bus.reg_pulse_cycles = 2;
        end
        n_cmp++;
        if (to_v[13:0] !== 14'h07FE) begin
            n_bad++;
            $display("FAIL pulse_latched got %h want %h", to_v[13:0], 14'h07FE);
        end
        quiet(3);
    endtask

    task automatic test_reset_mid_delay();
        set_cfg(10, 2, 0, 1'b0);
        bus.trig_req = 4'b1000;
        tick();
        bus.trig_req = 4'b0000;
        tick();
        bus.trig_req = 4'b0001;
        tick();
        bus.trig_req = 4'b0000;
        tick();
        bus.trig_req = 4'b0001;
        tick();
        bus.trig_req = 4'b0000;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.drop_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL pre_reset got busy=%b drop=%0d want 1/1",
                     bus.busy, bus.drop_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.trig_out !== 1'b0 || bus.busy !== 1'b0 ||
            bus.drop_cnt !== 16'd0 || bus.trig_src !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_mid_delay got out=%b busy=%b drop=%0d src=%0d want 0",
                     bus.trig_out, bus.busy, bus.drop_cnt, bus.trig_src);
        end
        tick();
        rst = 1'b0;
        to_v = '0;
        bz_v = '0;
        for (int i = 0; i < 20; i++) tick_rec(i);
        n_cmp++;
        if (to_v[19:0] !== 20'h0 || bz_v[19:0] !== 20'h0) begin
            n_bad++;
            $display("FAIL post_reset_idle got out=%h busy=%h want 0/0",
                     to_v[19:0], bz_v[19:0]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        to_v  = '0;
        bz_v  = '0;
        test_reset();
        test_single();
        test_fixed_prio();
        test_round_robin();
        test_overflow();
        test_config();
        test_drop_saturate();
        test_reset_mid_delay();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trigger_scheduler.md
Name: trigger_scheduler

Overview:
- Shares one camera/strobe trigger output between NUM_SRC trigger requesters: hardware line, software, encoder and timer.
- Arbitrates pending requests, then sequences the granted trigger through programmable delay, pulse width and holdoff phases.
- Keeps a one-deep pending slot per source and counts triggers that cannot be held.
- Sits upstream of the per-channel trigger gating, so trig_out feeds that stage's trigger input.

Parameters:
NUM_SRC, 4, number of trigger requesters (2..8)
CNT_W, 32, width of the delay/pulse/holdoff counters and config fields
DROP_W, 16, width of the saturating drop counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
reg_src_enable  in  NUM_SRC  per-source enable; 0 ignores the source and clears its pending bit
reg_rr_mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
reg_delay_cycles  in  CNT_W  cycles from grant to pulse start
reg_pulse_cycles  in  CNT_W  pulse width in cycles; 0 is treated as 1
reg_holdoff_cycles  in  CNT_W  dead time after pulse end before the next grant
reg_drop_clr  in  1  single-cycle strobe that clears drop_cnt
trig_req  in  NUM_SRC  trigger requests, already synchronized to clk; level or pulse
trig_out  out  1  scheduled trigger pulse, registered
trig_src  out  $clog2(NUM_SRC)  index of the source owning the current/last grant, registered
busy  out  1  high whenever the FSM is not in IDLE
drop_cnt  out  DROP_W  saturating count of dropped triggers

Behaviour:
- Reset: trig_out=0, trig_src=0, busy=0, drop_cnt=0; req_d, pending and counters are 0, RR pointer=0, FSM=IDLE. An async reset mid-pulse drops trig_out immediately.
- Edge detect: req_d <= trig_req each cycle; edge[i] = trig_req[i] & ~req_d[i] & reg_src_enable[i].
- Pending update, per source, every cycle:
  - disabled: clear.
  - edge and granted in the same cycle: stays set, so the new request is kept.
  - edge while set and not granted: stays set, drop_cnt increments.
  - edge otherwise: set.
  - granted without edge: clear.
- drop_cnt saturates at all-ones. reg_drop_clr has priority over an increment in the same cycle.
- Arbitration: evaluated only in IDLE with any pending bit set.
  - Fixed mode: lowest pending index wins.
  - RR mode: first pending index at or after ptr, wrapping; on grant ptr <= winner+1 mod NUM_SRC.
  - ptr holds its value while in fixed mode.
- Grant cycle (IDLE): latch reg_delay/pulse/holdoff into working registers, so config changes mid-sequence do not affect the current trigger. Set trig_src to the winner and clear the winner's pending bit.
- FSM states: IDLE, DELAY, PULSE, HOLDOFF.
  - IDLE -> DELAY on grant if delay>0, loading cnt=delay-1.
  - IDLE -> PULSE on grant if delay=0, loading cnt=max(pulse,1)-1.
  - DELAY: when cnt=0 -> PULSE with cnt=max(pulse,1)-1; otherwise cnt-1.
  - PULSE: trig_out=1. When cnt=0 -> HOLDOFF (cnt=holdoff-1) if holdoff>0, else IDLE; otherwise cnt-1.
  - HOLDOFF: when cnt=0 -> IDLE; otherwise cnt-1.
- trig_out is a registered decode of next-state==PULSE and is high exactly max(pulse,1) cycles.
- Latency: trig_req sampled high at edge N sets pending at N. Grant happens at N+1. With delay=0, trig_out is high from N+1.
- Minimum spacing between trig_out rising edges is delay+max(pulse,1)+holdoff+1 cycles (the IDLE grant cycle).
- Requests arriving in DELAY/PULSE/HOLDOFF are held one-deep per source. A second edge from the same source while its bit is pending is dropped.
- A trig_req held high produces one trigger only: edge-based, no retrigger.
- Clearing reg_src_enable mid-sequence does not abort the current pulse.

Decomposition:
- Package trigger_sched_pkg holds:
  - the state encoding (IDLE=2'd0, DELAY=2'd1, PULSE=2'd2, HOLDOFF=2'd3);
  - NUM_SRC_MAX=8;
  - the helper constant SRC_W=$clog2(NUM_SRC).
- One sub-module, trig_rr_arbiter: combinational winner/valid from pending, ptr and mode. The RR pointer is registered in the parent.

Test Plan:
- Single source: src0 edge, delay=0, pulse=4, holdoff=0 -> trig_out high 4 cycles starting 1 cycle after sampling, trig_src=0, busy for 4 cycles.
- Simultaneous edges on src1 and src3, fixed mode, delay=2, pulse=3, holdoff=5 -> src1 pulse first. src3 pulse rises 11 cycles (2+3+5+1) after src1's rise.
- RR mode with all 4 sources requesting repeatedly, delay=0, pulse=1, holdoff=0 -> trig_src cycles 0,1,2,3,0; no source is granted twice in a row while others are pending.
- Overflow: src2 edges 3 times during a 20-cycle pulse -> one pending trigger after HOLDOFF, drop_cnt=2. drop_cnt=0xFFFF stays at 0xFFFF; reg_drop_clr -> 0.
- Config robustness: pulse=0 -> 1-cycle pulse. Changing reg_pulse_cycles from 10 to 2 mid-PULSE -> current pulse is still 10 cycles.
- Reset mid-DELAY with src0 pending -> trig_out=0, busy=0, drop_cnt=0 immediately. After release, no trigger without a new edge.
